// File: rtl/pps_pkg.sv
// Shared constants for the writeback stage: default widths and load-type encodings.
// Load types select byte/half/word extraction in pps_load_align.
package pps_pkg;

  localparam int PPS_DATA_W = 32;
  localparam int PPS_REG_AW = 5;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

endpackage

// File: rtl/pps_load_align.sv
// Combinational load extraction: picks a little-endian byte/half lane from the raw
// load word and sign/zero extends it; W and undefined encodings pass the word through.
module pps_load_align
  import pps_pkg::*;
#(
  parameter int DATA_W = PPS_DATA_W
) (
  input  logic [DATA_W-1:0] raw_word,
  input  logic [2:0]        ld_type,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] ld_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_word[7:0];
    case (addr_lo)
      2'd1:    byte_sel = raw_word[15:8];
      2'd2:    byte_sel = raw_word[23:16];
      2'd3:    byte_sel = raw_word[31:24];
      default: byte_sel = raw_word[7:0];
    endcase
  end

  // Halfword lane comes from addr_lo[1] only; a misaligned bit 0 is ignored.
  always_comb begin
    half_sel = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
  end

  always_comb begin
    ld_data = raw_word;
    case (ld_type)
      LD_B:    ld_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
      LD_BU:   ld_data = {{(DATA_W-8){1'b0}}, byte_sel};
      LD_H:    ld_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
      LD_HU:   ld_data = {{(DATA_W-16){1'b0}}, half_sel};
      default: ld_data = raw_word;
    endcase
  end

endmodule

// File: rtl/pps_writeback_reg.sv
// Registered MEM/WB stage: 1-cycle latency, stall holds, flush (wins over stall) invalidates.
// Write enables are qualified for r0 and same-cycle WAW; a retired-instruction counter is exported.
module pps_writeback_reg
  import pps_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int DATA_W   = PPS_DATA_W,
  parameter int REG_AW   = PPS_REG_AW,
  parameter int RWE_SIZE = 1,
  parameter int CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       WB_stall_in,
  input  logic                       WB_flush_in,
  input  logic [NUM_CH-1:0]          WB_valid_in,
  input  logic [NUM_CH*REG_AW-1:0]   WB_inst_rd_in,
  input  logic [NUM_CH*RWE_SIZE-1:0] WB_RegWrite_in,
  input  logic [NUM_CH*DATA_W-1:0]   WB_alu_data_in,
  input  logic [NUM_CH*DATA_W-1:0]   WB_mem_data_in,
  input  logic [NUM_CH-1:0]          WB_MemToReg_in,
  input  logic [NUM_CH*3-1:0]        WB_ld_type_in,
  input  logic [NUM_CH*2-1:0]        WB_addr_lo_in,
  output logic [NUM_CH*REG_AW-1:0]   WB_inst_rd_out,
  output logic [NUM_CH*RWE_SIZE-1:0] WB_RegWrite_out,
  output logic [NUM_CH*DATA_W-1:0]   WB_RF_Wdata_out,
  output logic [NUM_CH-1:0]          WB_valid_out,
  output logic [CNT_W-1:0]           WB_retired_cnt_out
);

  logic [NUM_CH-1:0]          valid_d, valid_q;
  logic [NUM_CH*REG_AW-1:0]   rd_d, rd_q;
  logic [NUM_CH*RWE_SIZE-1:0] rwe_d, rwe_q;
  logic [NUM_CH*DATA_W-1:0]   data_d, data_q;
  logic [CNT_W-1:0]           cnt_d, cnt_q;

  logic [NUM_CH*DATA_W-1:0]   ld_data;
  logic [CNT_W-1:0]           retire_inc;
  logic [NUM_CH-1:0]          wr_keep;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_align
    pps_load_align #(.DATA_W(DATA_W)) u_align (
      .raw_word (WB_mem_data_in[c*DATA_W +: DATA_W]),
      .ld_type  (WB_ld_type_in[c*3 +: 3]),
      .addr_lo  (WB_addr_lo_in[c*2 +: 2]),
      .ld_data  (ld_data[c*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    retire_inc = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      retire_inc = retire_inc + CNT_W'(WB_valid_in[c]);
    end
  end

  always_comb begin
    valid_d = valid_q;
    rd_d    = rd_q;
    rwe_d   = rwe_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (WB_flush_in) begin
      valid_d = '0;
      rd_d    = '0;
      rwe_d   = '0;
      data_d  = '0;
    end else if (!WB_stall_in) begin
      valid_d = WB_valid_in;
      rd_d    = WB_inst_rd_in;
      rwe_d   = WB_RegWrite_in;
      for (int c = 0; c < NUM_CH; c++) begin
        data_d[c*DATA_W +: DATA_W] = WB_MemToReg_in[c] ? ld_data[c*DATA_W +: DATA_W]
                                                       : WB_alu_data_in[c*DATA_W +: DATA_W];
      end
      cnt_d = cnt_q + retire_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      rd_q    <= '0;
      rwe_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rd_q    <= rd_d;
      rwe_q   <= rwe_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // A write survives only if no younger valid writer targets the same register.
  always_comb begin
    wr_keep = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      wr_keep[c] = valid_q[c] && (rd_q[c*REG_AW +: REG_AW] != '0);
      for (int j = c + 1; j < NUM_CH; j++) begin
        if (valid_q[j] && (|rwe_q[j*RWE_SIZE +: RWE_SIZE]) &&
            (rd_q[j*REG_AW +: REG_AW] == rd_q[c*REG_AW +: REG_AW])) begin
          wr_keep[c] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    WB_RegWrite_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      WB_RegWrite_out[c*RWE_SIZE +: RWE_SIZE] = wr_keep[c] ? rwe_q[c*RWE_SIZE +: RWE_SIZE]
                                                           : '0;
    end
  end

  assign WB_inst_rd_out     = rd_q;
  assign WB_RF_Wdata_out    = data_q;
  assign WB_valid_out       = valid_q;
  assign WB_retired_cnt_out = cnt_q;

endmodule

// File: tb/tb_pps_writeback_reg.sv
// Scoreboarded bench for pps_writeback_reg: expected slots are queued at drive time
// and compared after the capturing edge; a 4-bit-counter instance covers wrap.
module tb_pps_writeback_reg;
  import pps_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  valid_in;
  logic [9:0]  rd_in;
  logic [1:0]  rwe_in;
  logic [63:0] alu_in;
  logic [63:0] mem_in;
  logic [1:0]  m2r_in;
  logic [5:0]  ldt_in;
  logic [3:0]  alo_in;

  logic [9:0]  rd_out;
  logic [1:0]  rwe_out;
  logic [63:0] wdata_out;
  logic [1:0]  valid_out;
  logic [31:0] cnt_out;

  logic [9:0]  w_rd;
  logic [1:0]  w_rwe;
  logic [63:0] w_data;
  logic [1:0]  w_vld;
  logic [3:0]  w_cnt;

  always #5 clk = ~clk;

  pps_writeback_reg dut (
    .clk(clk), .rst_n(rst_n), .WB_stall_in(stall), .WB_flush_in(flush),
    .WB_valid_in(valid_in), .WB_inst_rd_in(rd_in), .WB_RegWrite_in(rwe_in),
    .WB_alu_data_in(alu_in), .WB_mem_data_in(mem_in), .WB_MemToReg_in(m2r_in),
    .WB_ld_type_in(ldt_in), .WB_addr_lo_in(alo_in),
    .WB_inst_rd_out(rd_out), .WB_RegWrite_out(rwe_out), .WB_RF_Wdata_out(wdata_out),
    .WB_valid_out(valid_out), .WB_retired_cnt_out(cnt_out)
  );

  pps_writeback_reg #(.CNT_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .WB_stall_in(stall), .WB_flush_in(flush),
    .WB_valid_in(valid_in), .WB_inst_rd_in(rd_in), .WB_RegWrite_in(rwe_in),
    .WB_alu_data_in(alu_in), .WB_mem_data_in(mem_in), .WB_MemToReg_in(m2r_in),
    .WB_ld_type_in(ldt_in), .WB_addr_lo_in(alo_in),
    .WB_inst_rd_out(w_rd), .WB_RegWrite_out(w_rwe), .WB_RF_Wdata_out(w_data),
    .WB_valid_out(w_vld), .WB_retired_cnt_out(w_cnt)
  );

  typedef struct packed {
    logic [9:0]  rd;
    logic [1:0]  rwe;
    logic [63:0] data;
    logic [1:0]  vld;
    logic [31:0] cnt;
  } obs_t;

  obs_t        sb[$];
  logic [31:0] cnt_sb[$];
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] model_cnt = 32'd0;

  function automatic obs_t sample();
    obs_t s;
    s.rd   = rd_out;
    s.rwe  = rwe_out;
    s.data = wdata_out;
    s.vld  = valid_out;
    s.cnt  = cnt_out;
    return s;
  endfunction

  function automatic string fmt(input obs_t s);
    return $sformatf("rd=%h we=%b data=%h vld=%b cnt=%0d", s.rd, s.rwe, s.data, s.vld, s.cnt);
  endfunction

  task automatic clear_inputs();
    valid_in = '0; rd_in = '0; rwe_in = '0; alu_in = '0;
    mem_in = '0; m2r_in = '0; ldt_in = '0; alo_in = '0;
  endtask

  task automatic set_ch(input int c, input logic v, input logic [4:0] rd, input logic we,
                        input logic [31:0] alu, input logic [31:0] mem, input logic m2r,
                        input logic [2:0] lt, input logic [1:0] lo);
    valid_in[c]        = v;
    rd_in[c*5 +: 5]    = rd;
    rwe_in[c]          = we;
    alu_in[c*32 +: 32] = alu;
    mem_in[c*32 +: 32] = mem;
    m2r_in[c]          = m2r;
    ldt_in[c*3 +: 3]   = lt;
    alo_in[c*2 +: 2]   = lo;
  endtask

  // Counter reference: advances by the number of valid channels on a plain capture edge.
  task automatic predict(input logic st, input logic fl);
    stall = st;
    flush = fl;
    if (!fl && !st) model_cnt = model_cnt + 32'(valid_in[0]) + 32'(valid_in[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    tick();
    rst_n = 1'b1;
    model_cnt = 32'd0;
  endtask

  task automatic test_reset();
    obs_t got, e;
    #1 rst_n = 1'b0;
    #1;
    got = sample();
    n_vec++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset_init: got %s want all zero", fmt(got));
    end
    n_vec++;
    if ({w_rd, w_rwe, w_data, w_vld, w_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_init_w: got rd=%h we=%b data=%h vld=%b cnt=%0d want all zero",
               w_rd, w_rwe, w_data, w_vld, w_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    set_ch(0, 1'b1, 5'd12, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0, LD_W, 2'd0);
    set_ch(1, 1'b1, 5'd13, 1'b1, 32'h0BADBEEF, 32'h0, 1'b0, LD_W, 2'd0);
    predict(1'b0, 1'b0);
    e = '{rd: {5'd13, 5'd12}, rwe: 2'b11, data: {32'h0BADBEEF, 32'hCAFEF00D},
          vld: 2'b11, cnt: model_cnt};
    sb.push_back(e);
    tick();
    got = sample();
    e = sb.pop_front();
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL reset_pre: got %s want %s", fmt(got), fmt(e));
    end
    rst_n = 1'b0;
    #1;
    got = sample();
    n_vec++;
    if (got !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got %s want all zero", fmt(got));
    end
    n_vec++;
    if ({w_rd, w_rwe, w_data, w_vld, w_cnt} !== '0) begin
      n_bad++;
      $display("FAIL reset_async_w: got rd=%h we=%b data=%h vld=%b cnt=%0d want all zero",
               w_rd, w_rwe, w_data, w_vld, w_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 32'd0;
  endtask

  task automatic test_load();
    obs_t got, e;
    logic [2:0]  lt0 [5];
    logic [1:0]  lo0 [5];
    logic [31:0] x0  [5];
    logic [2:0]  lt1 [5];
    logic [1:0]  lo1 [5];
    logic [31:0] x1  [5];
    lt0 = '{LD_B, LD_BU, LD_H, LD_HU, LD_W};
    lo0 = '{2'd2, 2'd0, 2'd2, 2'd0, 2'd0};
    x0  = '{32'hFFFFFF99, 32'h000000BB, 32'hFFFF8899, 32'h0000AABB, 32'h8899AABB};
    lt1 = '{LD_B, LD_BU, LD_H, LD_HU, 3'd6};
    lo1 = '{2'd0, 2'd3, 2'd3, 2'd1, 2'd2};
    x1  = '{32'hFFFFFFFE, 32'h0000007F, 32'h00007F80, 32'h000001FE, 32'h7F8001FE};
    for (int k = 0; k < 5; k++) begin
      clear_inputs();
      set_ch(0, 1'b1, 5'd3, 1'b1, 32'hDEAD0000, 32'h8899AABB, 1'b1, lt0[k], lo0[k]);
      set_ch(1, 1'b1, 5'd4, 1'b1, 32'hDEAD0001, 32'h7F8001FE, 1'b1, lt1[k], lo1[k]);
      predict(1'b0, 1'b0);
      e = '{rd: {5'd4, 5'd3}, rwe: 2'b11, data: {x1[k], x0[k]}, vld: 2'b11, cnt: model_cnt};
      sb.push_back(e);
      tick();
      got = sample();
      e = sb.pop_front();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL load[%0d]: got %s want %s", k, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_waw();
    obs_t got, e;
    logic        v0 [6], v1 [6], we0 [6], we1 [6];
    logic [4:0]  r0 [6], r1 [6];
    logic [31:0] a0 [6], a1 [6];
    logic [1:0]  xwe [6];
    v0  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    r0  = '{5'd7, 5'd0, 5'd9, 5'd9, 5'd0, 5'd31};
    we0 = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    a0  = '{32'h11, 32'hAB, 32'h33, 32'h55, 32'h77, 32'h99};
    v1  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    r1  = '{5'd7, 5'd0, 5'd9, 5'd9, 5'd0, 5'd30};
    we1 = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    a1  = '{32'h22, 32'h00, 32'h44, 32'h66, 32'h88, 32'hAA};
    xwe = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b11};
    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      set_ch(0, v0[k], r0[k], we0[k], a0[k], 32'hFFFFFFFF, 1'b0, LD_B, 2'd0);
      set_ch(1, v1[k], r1[k], we1[k], a1[k], 32'hFFFFFFFF, 1'b0, LD_B, 2'd0);
      predict(1'b0, 1'b0);
      e = '{rd: {r1[k], r0[k]}, rwe: xwe[k], data: {a1[k], a0[k]},
            vld: {v1[k], v0[k]}, cnt: model_cnt};
      sb.push_back(e);
      tick();
      got = sample();
      e = sb.pop_front();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL waw[%0d]: got %s want %s", k, fmt(got), fmt(e));
      end
    end
  endtask

  task automatic test_invalid();
    obs_t got, e;
    logic [31:0] cnt_before;
    cnt_before = model_cnt;
    clear_inputs();
    set_ch(0, 1'b0, 5'd5, 1'b1, 32'h77, 32'h0, 1'b0, LD_W, 2'd0);
    set_ch(1, 1'b0, 5'd5, 1'b1, 32'h88, 32'h0, 1'b0, LD_W, 2'd0);
    predict(1'b0, 1'b0);
    e = '{rd: {5'd5, 5'd5}, rwe: 2'b00, data: {32'h88, 32'h77}, vld: 2'b00, cnt: cnt_before};
    sb.push_back(e);
    tick();
    got = sample();
    e = sb.pop_front();
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL invalid: got %s want %s", fmt(got), fmt(e));
    end
  endtask

  task automatic test_stall();
    obs_t got, e, held;
    clear_inputs();
    set_ch(0, 1'b1, 5'd2, 1'b1, 32'h12345678, 32'h0, 1'b0, LD_W, 2'd0);
    predict(1'b0, 1'b0);
    held = '{rd: {5'd0, 5'd2}, rwe: 2'b01, data: {32'h0, 32'h12345678}, vld: 2'b01, cnt: model_cnt};
    sb.push_back(held);
    tick();
    got = sample();
    e = sb.pop_front();
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL stall_load: got %s want %s", fmt(got), fmt(e));
    end
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 1'b1, 5'd6, 1'b1, 32'($urandom), 32'($urandom), 1'b1, LD_BU, 2'(k));
      set_ch(1, 1'b1, 5'd6 + 5'(k), 1'b1, 32'($urandom), 32'h0, 1'b0, LD_W, 2'd0);
      predict(1'b1, 1'b0);
      sb.push_back(held);
      tick();
      got = sample();
      e = sb.pop_front();
      n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL stall_hold[%0d]: got %s want %s", k, fmt(got), fmt(e));
      end
    end
    predict(1'b1, 1'b1);
    e = '{rd: '0, rwe: 2'b00, data: '0, vld: 2'b00, cnt: model_cnt};
    sb.push_back(e);
    tick();
    got = sample();
    e = sb.pop_front();
    n_vec++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL stall_flush: got %s want %s", fmt(got), fmt(e));
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_counter();
    logic [31:0] want;
    do_reset();
    clear_inputs();
    set_ch(0, 1'b1, 5'd1, 1'b1, 32'h1, 32'h0, 1'b0, LD_W, 2'd0);
    set_ch(1, 1'b1, 5'd2, 1'b1, 32'h2, 32'h0, 1'b0, LD_W, 2'd0);
    for (int k = 0; k < 6; k++) begin
      if (k < 4)       predict(1'b0, 1'b0);
      else if (k == 4) predict(1'b1, 1'b0);
      else             predict(1'b0, 1'b1);
      cnt_sb.push_back((k < 4) ? 32'((k + 1) * 2) : 32'd8);
      tick();
      want = cnt_sb.pop_front();
      n_vec++;
      if (cnt_out !== want) begin
        n_bad++;
        $display("FAIL counter[%0d]: got cnt=%0d want cnt=%0d", k, cnt_out, want);
      end
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_wrap();
    logic [31:0] want;
    do_reset();
    clear_inputs();
    set_ch(0, 1'b1, 5'd1, 1'b1, 32'h1, 32'h0, 1'b0, LD_W, 2'd0);
    set_ch(1, 1'b1, 5'd2, 1'b1, 32'h2, 32'h0, 1'b0, LD_W, 2'd0);
    for (int k = 0; k < 7; k++) begin
      predict(1'b0, 1'b0);
      tick();
    end
    valid_in[1] = 1'b0;
    predict(1'b0, 1'b0);
    cnt_sb.push_back(32'd15);
    tick();
    want = cnt_sb.pop_front();
    n_vec++;
    if (32'(w_cnt) !== want) begin
      n_bad++;
      $display("FAIL wrap_pre: got cnt=%0d want cnt=%0d", w_cnt, want);
    end
    valid_in[1] = 1'b1;
    predict(1'b0, 1'b0);
    cnt_sb.push_back(32'd1);
    tick();
    want = cnt_sb.pop_front();
    n_vec++;
    if (32'(w_cnt) !== want) begin
      n_bad++;
      $display("FAIL wrap: got cnt=%0d want cnt=%0d", w_cnt, want);
    end
    n_vec++;
    if (cnt_out !== 32'd17) begin
      n_bad++;
      $display("FAIL wrap_wide: got cnt=%0d want cnt=17", cnt_out);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load();
    test_waw();
    test_invalid();
    test_stall();
    test_counter();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
